// File: rtl/triangle_if.sv
// Sample bus from the triangle generator: the enable and the current sample.
// The generator side drives it (master); the monitor only observes it (slave).
// A sample transfers on every rising clock edge where ena is high. There is
// no back-pressure: the monitor always accepts.
interface triangle_if #(
  parameter int N = 8
);
  logic         ena;
  logic [N-1:0] in;

  modport master (output ena, output in);
  modport slave  (input  ena, input  in);
endinterface

// File: rtl/triangle_monitor.sv
// triangle_monitor: receive-side checker for the triangle generator stream.
// It tracks the ramp direction, flags peaks and troughs, and measures the
// trough-to-trough period in accepted samples. It also reports step errors
// and lock status.
// Optional feature: define TRIANGLE_MONITOR_HOLD_EN to treat a repeated
// sample as a legal hold instead of a step error.
// dbg_state exposes the FSM state (0 SYNC, 1 ACQ, 2 UP, 3 DOWN).
module triangle_monitor #(
  parameter int N        = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  triangle_if.slave           bus,
  output logic                dir,
  output logic                peak,
  output logic                trough,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                step_err,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    ACQ  = 2'd1,
    UP   = 2'd2,
    DOWN = 2'd3
  } state_t;

  localparam logic [N-1:0]        MAX     = '1;
  localparam logic [N-1:0]        ZERO    = '0;
  localparam logic [N-1:0]        ONE     = N'(1);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

  state_t              state, state_n;
  logic [N-1:0]        prev, prev_n;
  logic [PERIOD_W-1:0] cnt, cnt_n, cnt_inc;
  logic                have_trough, have_trough_n;
  logic [PERIOD_W-1:0] period_n;
  logic                locked_n, peak_n, trough_n, period_valid_n, step_err_n;
  logic                rise, fall, hold;

  // Step classification of the incoming sample against the reference.
  always_comb begin
    rise    = (prev != MAX)  && (bus.in == prev + ONE);
    fall    = (prev != ZERO) && (bus.in == prev - ONE);
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  end

`ifdef TRIANGLE_MONITOR_HOLD_EN
  assign hold = (bus.in == prev);
`else
  assign hold = 1'b0;
`endif

  // Next-state, counter and output logic. Nothing moves without ena.
  always_comb begin
    state_n        = state;
    prev_n         = prev;
    cnt_n          = cnt;
    have_trough_n  = have_trough;
    period_n       = period;
    locked_n       = locked;
    peak_n         = 1'b0;
    trough_n       = 1'b0;
    period_valid_n = 1'b0;
    step_err_n     = 1'b0;

    if (bus.ena) begin
      prev_n = bus.in;
      if (state == SYNC) begin
        // First sample only establishes the reference.
        state_n = ACQ;
        cnt_n   = cnt_inc;
      end else if (hold) begin
        // Legal hold: the sample is not counted and the state is kept.
        state_n = state;
      end else if (rise && (state != DOWN)) begin
        cnt_n = cnt_inc;
        if (bus.in == MAX) begin
          peak_n  = 1'b1;
          state_n = DOWN;
        end else begin
          state_n = UP;
        end
      end else if (fall && (state != UP)) begin
        cnt_n = cnt_inc;
        if (bus.in == ZERO) begin
          trough_n = 1'b1;
          state_n  = UP;
          // cnt_inc already includes this trough sample in the distance.
          if (have_trough) begin
            period_n       = cnt_inc;
            period_valid_n = 1'b1;
            locked_n       = 1'b1;
          end
          cnt_n         = '0;
          have_trough_n = 1'b1;
        end else begin
          state_n = DOWN;
        end
      end else begin
        // Wrong direction, repeat, wrap or jump: drop the lock and restart.
        cnt_n         = cnt_inc;
        step_err_n    = 1'b1;
        state_n       = ACQ;
        locked_n      = 1'b0;
        have_trough_n = 1'b0;
      end
    end
  end

  // State, reference sample and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SYNC;
      prev         <= '0;
      cnt          <= '0;
      have_trough  <= 1'b0;
      dir          <= 1'b0;
      peak         <= 1'b0;
      trough       <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      step_err     <= 1'b0;
    end else begin
      state        <= state_n;
      prev         <= prev_n;
      cnt          <= cnt_n;
      have_trough  <= have_trough_n;
      dir          <= (state_n == DOWN);
      peak         <= peak_n;
      trough       <= trough_n;
      period       <= period_n;
      period_valid <= period_valid_n;
      locked       <= locked_n;
      step_err     <= step_err_n;
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/triangle_monitor.md
# triangle_monitor

Receive-side checker for the triangle-wave stream driven by the on-chip N-bit triangle generator. It consumes one sample per enabled cycle and tracks the ramp direction. It flags each peak and each trough, measures the trough-to-trough period in samples, and reports lock and step errors. It sits on the generator's output bus and shares the generator's enable, so it sees exactly the samples the generator advanced on.

## Interface
- `N`, 8: sample width; N >= 2; MAX = 2^N-1.
- `PERIOD_W`, 16: width of the period counter and result.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  sample valid; a sample is accepted on any rising edge with `ena`=1.
- `in`  in  N  triangle sample.
- `dir`  out  1  current ramp direction: 0 = up, 1 = down.
- `peak`  out  1  one-cycle pulse: an accepted sample completed a rise to MAX.
- `trough`  out  1  one-cycle pulse: an accepted sample completed a fall to 0.
- `period`  out  PERIOD_W  last measured trough-to-trough distance, in accepted samples.
- `period_valid`  out  1  one-cycle pulse whenever `period` is updated.
- `locked`  out  1  high once a full clean period has been measured; cleared on error.
- `step_err`  out  1  one-cycle pulse: an accepted sample violated the expected step.

## Operation
- States: SYNC (no reference sample), ACQ (reference held, direction unknown), UP, DOWN. Reset state is SYNC.
- Register `prev`[N-1:0] holds the last accepted sample. Every accepted sample loads `prev` <= `in`.
- SYNC: the first accepted sample goes to ACQ. No pulses are generated.
- ACQ, UP and DOWN apply the same step rules:
  - `in`==`prev`+1 with `prev`<MAX: rising step. If `in`==MAX, pulse `peak` and go to DOWN; otherwise go to UP.
  - `in`==`prev`-1 with `prev`>0: falling step. If `in`==0, pulse `trough` and go to UP; otherwise go to DOWN.
  - In UP, a falling step is an error. In DOWN, a rising step is an error.
  - Any other value is an error. This includes a repeat of `prev`, a wrap from MAX to 0 or 0 to MAX, and any jump.
- On error: pulse `step_err`, go to ACQ, clear `locked` and `have_trough`. `period` holds its last value.
- Period counter `cnt`[PERIOD_W-1:0]:
  - Increments on every accepted sample and saturates at 2^PERIOD_W-1.
  - On a trough event: if `have_trough`=1, set `period` <= `cnt`+1 (saturating), pulse `period_valid`, and set `locked`=1.
  - On every trough event, then set `cnt` <= 0 and `have_trough` <= 1.
- `dir` follows the state: 0 in SYNC, ACQ and UP; 1 in DOWN.
- With `ena`=0 nothing changes and all pulse outputs are 0.

## Timing
- All outputs are registered. Pulses and the `dir`/`locked`/`period` updates are visible on the cycle after the edge that accepted the sample.
- Latency is 1 clock from sample acceptance to response.
- Pulses last exactly one cycle, even when `ena` stays high.
- Reset values: `dir`=0, `peak`=0, `trough`=0, `period`=0, `period_valid`=0, `locked`=0, `step_err`=0. Internal reset values: `prev`=0, `cnt`=0, `have_trough`=0, state SYNC.
- Reset is asynchronous: asserting `rst` mid-stream clears outputs immediately. After release, the monitor reacquires starting from SYNC.
- Clean stream from the generator with `ena` held high: sequence 0,1,…,MAX,MAX-1,…,1,0. This gives period = 2·MAX (510 for N=8) and `peak`/`trough` spaced MAX samples apart.
- Sample gaps (`ena`=0) are not counted. Period is measured in samples, not clocks.

## Configuration
- `TRIANGLE_MONITOR_HOLD_EN`:
  - Defined: an accepted sample equal to `prev` is a legal hold. State, `dir` and `locked` are unchanged, no pulse is generated, and `cnt` does not increment.
  - Undefined: a repeated sample is a step error.

## Test plan
- Reset, then `ena`=1 driving 0,1,…,255,254,…,0,1,…,0 (N=8) -> `trough` on both zeros; `peak` at 255 with `dir`->1 on the next cycle; on the second trough, `period`=510, `period_valid` pulses once, and `locked`=1.
- Start mid-ramp at 100,101,102 -> ACQ then UP with no error; the first trough gives no `period_valid`; the second trough gives `period`=510.
- While locked and counting up at 40, inject 43 -> `step_err` pulses once, `locked`=0, `period` still 510, and the state is ACQ. Continuing with 44,45,… returns to UP, and `locked` reasserts only after two further troughs.
- Toggle `ena` 1/0 every cycle over a clean ramp -> same `peak`/`trough` sequence and `period`=510; no pulse appears in any cycle following an `ena`=0 edge.
- Inject 255→0 wrap -> `step_err`. Separately, inject a repeated sample 77,77 -> `step_err` when the macro is undefined; with `TRIANGLE_MONITOR_HOLD_EN` defined, no error and `period` is still 510.
- Assert `rst` asynchronously mid-DOWN at sample 120 -> all outputs are 0 before the next edge; after release, reacquisition completes with no spurious pulses.
